// File: rtl/qspi_flash_responder.sv
// QSPI serial-NOR flash responder backed by a synchronous byte memory.
// Oversamples SCK/CSB/IO with clk, decodes READ (0x03) and QUAD I/O
// FAST READ (0xEB, with continuous-read mode), and streams memory bytes.
module qspi_flash_responder #(
    parameter int ADDR_W = 16,
    parameter int DUMMY  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_csb,
    input  logic [3:0]        spi_io_di,
    output logic [3:0]        spi_io_do,
    output logic [3:0]        spi_io_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR_S, ADDR_Q, MODE, DUMMY_CYC, DATA_S, DATA_Q, IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  sck_sync, csb_sync;
    logic [3:0]  io_m, io_s;
    logic        sck_q, csb_q;
    logic        sck_rise, sck_fall, csb_rise, csb_fall;
    logic        cont_mode;
    logic [22:0] in_sr;     // incoming opcode/address/mode bits
    logic [4:0]  in_cnt;    // rises seen in the current input phase
    logic [2:0]  out_cnt;   // falls seen in the current output byte
    logic [7:0]  sh;        // output byte shifter
    logic [7:0]  pbuf;      // prefetched next byte
    logic        rd_dst;    // 0: read targets shifter, 1: prefetch buffer
    logic        rd_vld;    // mem_rdata is valid this clk

    assign sck_rise = sck_sync[1] & ~sck_q;
    assign sck_fall = ~sck_sync[1] & sck_q;
    assign csb_rise = csb_sync[1] & ~csb_q;
    assign csb_fall = ~csb_sync[1] & csb_q;

    // Two-flop synchronizers plus a delayed copy for edge detection;
    // IO goes through the same depth so it lines up with the SCK edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= 2'b00;
            csb_sync <= 2'b11;
            io_m     <= 4'h0;
            io_s     <= 4'h0;
            sck_q    <= 1'b0;
            csb_q    <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[0], spi_clk};
            csb_sync <= {csb_sync[0], spi_csb};
            io_m     <= spi_io_di;
            io_s     <= io_m;
            sck_q    <= sck_sync[1];
            csb_q    <= csb_sync[1];
        end
    end

    // Protocol FSM: shift inputs on SCK rise, drive data on SCK fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cont_mode <= 1'b0;
            in_sr     <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            sh        <= '0;
            pbuf      <= '0;
            rd_dst    <= 1'b0;
            rd_vld    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            spi_io_do <= 4'h0;
            spi_io_oe <= 4'h0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            rd_vld  <= mem_rd;
            if (rd_vld) begin
                if (rd_dst) pbuf <= mem_rdata;
                else        sh   <= mem_rdata;
            end

            if (csb_rise) begin
                state     <= IDLE;
                spi_io_oe <= 4'h0;
                in_cnt    <= '0;
                out_cnt   <= '0;
                busy      <= 1'b0;
            end else if (csb_fall) begin
                state   <= cont_mode ? ADDR_Q : CMD;
                in_cnt  <= '0;
                out_cnt <= '0;
                busy    <= 1'b1;
            end else if (sck_rise) begin
                case (state)
                    CMD: begin
                        in_sr  <= {in_sr[21:0], io_s[0]};
                        in_cnt <= in_cnt + 5'd1;
                        if (in_cnt == 5'd7) begin
                            in_cnt <= '0;
                            case ({in_sr[6:0], io_s[0]})
                                8'h03:        state <= ADDR_S;
                                8'hEB:        state <= ADDR_Q;
                                8'hFF, 8'hAB: begin
                                    state     <= IGNORE;
                                    cont_mode <= 1'b0;
                                end
                                default: begin
                                    state   <= IGNORE;
                                    cmd_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ADDR_S: begin
                        in_sr  <= {in_sr[21:0], io_s[0]};
                        in_cnt <= in_cnt + 5'd1;
                        if (in_cnt == 5'd23) begin
                            in_cnt   <= '0;
                            out_cnt  <= '0;
                            mem_addr <= ADDR_W'({in_sr[22:0], io_s[0]});
                            mem_rd   <= 1'b1;
                            rd_dst   <= 1'b0;
                            state    <= DATA_S;
                        end
                    end
                    ADDR_Q: begin
                        in_sr  <= {in_sr[18:0], io_s};
                        in_cnt <= in_cnt + 5'd1;
                        if (in_cnt == 5'd5) begin
                            in_cnt   <= '0;
                            mem_addr <= ADDR_W'({in_sr[19:0], io_s});
                            mem_rd   <= 1'b1;
                            rd_dst   <= 1'b0;
                            state    <= MODE;
                        end
                    end
                    MODE: begin
                        in_sr  <= {in_sr[18:0], io_s};
                        in_cnt <= in_cnt + 5'd1;
                        if (in_cnt == 5'd1) begin
                            in_cnt <= '0;
                            // mode[5:4] is the low half of the first nibble
                            cont_mode <= (in_sr[1:0] == 2'b10);
                            out_cnt   <= '0;
                            state     <= (DUMMY == 0) ? DATA_Q : DUMMY_CYC;
                        end
                    end
                    DUMMY_CYC: begin
                        in_cnt <= in_cnt + 5'd1;
                        if (in_cnt == 5'(DUMMY - 1)) begin
                            in_cnt  <= '0;
                            out_cnt <= '0;
                            state   <= DATA_Q;
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall) begin
                case (state)
                    DATA_S: begin
                        spi_io_oe <= 4'b0010;
                        spi_io_do <= {2'b00, sh[7], 1'b0};
                        sh        <= {sh[6:0], 1'b0};
                        out_cnt   <= out_cnt + 3'd1;
                        if (out_cnt == 3'd0) begin
                            mem_addr <= mem_addr + 1'b1;
                            mem_rd   <= 1'b1;
                            rd_dst   <= 1'b1;
                        end
                        if (out_cnt == 3'd7) sh <= pbuf;
                    end
                    DATA_Q: begin
                        spi_io_oe <= 4'b1111;
                        spi_io_do <= sh[7:4];
                        sh        <= {sh[3:0], 4'h0};
                        out_cnt   <= {2'b00, ~out_cnt[0]};
                        if (!out_cnt[0]) begin
                            mem_addr <= mem_addr + 1'b1;
                            mem_rd   <= 1'b1;
                            rd_dst   <= 1'b1;
                        end else begin
                            sh <= pbuf;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
